// File: rtl/input_debounce_pkg.sv
// Shared helpers for the input conditioning blocks: time-to-cycle conversion,
// counter sizing and the registered pulse bundle.
package input_debounce_pkg;

    // Registered one-cycle event outputs of a debounced input.
    typedef struct packed {
        logic press;
        logic rel;
        logic lng;
    } pulse_t;

    // Milliseconds to clock cycles, never less than one cycle.
    function automatic int unsigned ms_to_cycles(input int unsigned f_clk_hz,
                                                 input int unsigned ms);
        int unsigned t;
        t = f_clk_hz / 1000 * ms;
        return (t < 1) ? 1 : t;
    endfunction

    // Width of a counter that must be able to hold the value t.
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/input_debounce_sync.sv
// Two-flop synchroniser for a single asynchronous pin. RESET_VAL is the
// level loaded on reset so an idle pin does not look like an event.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_d, s1_q;
    logic s2_d, s2_q;

    // Plain shift through two stages.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Synchroniser flops, reset to the inactive pin level.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/input_debounce.sv
// Debounced push-button input: 2FF sync, debounce counter, registered
// press/release pulses and long-press detection.
// Optional auto-repeat while held: define INPUT_DEBOUNCE_REPEAT_EN.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int unsigned F_CLK_HZ      = 25_000_000,
    parameter int unsigned DEBOUNCE_MS   = 20,
    parameter int unsigned LONG_MS       = 1000,
    parameter int unsigned IN_ACTIVE_LOW = 0,
    parameter int unsigned REPEAT_MS     = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic I1,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic held
);

    localparam int unsigned DB_T   = ms_to_cycles(F_CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned DB_W   = cnt_width(DB_T);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_T - 1);

    localparam int unsigned LONG_T = ms_to_cycles(F_CLK_HZ, LONG_MS);
    localparam int unsigned LP_W   = cnt_width(LONG_T);
    localparam logic [LP_W-1:0] LONG_MAX = LP_W'(LONG_T - 1);

    localparam logic INV = (IN_ACTIVE_LOW != 0);

    logic s2;
    logic act;

    logic [DB_W-1:0] db_cnt_d, db_cnt_q;
    logic [LP_W-1:0] lp_cnt_d, lp_cnt_q;
    logic            level_d, level_q;
    logic            held_d, held_q;
    pulse_t          pulse_d, pulse_q;
    logic            long_fire;
    logic            rep_fire;

    sync_2ff #(.RESET_VAL(INV)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (I1),
        .q   (s2)
    );

    assign act = s2 ^ INV;

`ifdef INPUT_DEBOUNCE_REPEAT_EN
    localparam int unsigned REP_T = ms_to_cycles(F_CLK_HZ, REPEAT_MS);
    localparam int unsigned RP_W  = cnt_width(REP_T);
    localparam logic [RP_W-1:0] REP_MAX = RP_W'(REP_T - 1);

    logic [RP_W-1:0] rep_cnt_d, rep_cnt_q;

    // Repeat timer runs only while held; a repeat that would land on the
    // release edge is dropped so press and release never coincide.
    always_comb begin
        rep_fire  = held_q & level_d & (rep_cnt_q == REP_MAX);
        rep_cnt_d = '0;
        if (held_q && level_d && !rep_fire)
            rep_cnt_d = rep_cnt_q + 1'b1;
    end

    // Repeat counter state.
    always_ff @(posedge clk) begin
        if (rst) rep_cnt_q <= '0;
        else     rep_cnt_q <= rep_cnt_d;
    end
`else
    logic unused_repeat;
    assign unused_repeat = (REPEAT_MS == 0);
    assign rep_fire      = 1'b0;
`endif

    // Debounce, long-press and pulse next-state logic.
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (act == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_MAX) begin
            level_d  = act;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end

        // Long press fires once per hold; suppressed if release lands now.
        long_fire = level_q & level_d & ~held_q & (lp_cnt_q == LONG_MAX);

        lp_cnt_d = lp_cnt_q;
        if (!level_q)
            lp_cnt_d = '0;
        else if (!held_q && lp_cnt_q != LONG_MAX)
            lp_cnt_d = lp_cnt_q + 1'b1;

        // held drops on the same edge that raises release_pulse.
        held_d = level_d & (held_q | long_fire);

        pulse_d.press = (level_d & ~level_q) | rep_fire;
        pulse_d.rel   = ~level_d & level_q;
        pulse_d.lng   = long_fire;
    end

    // Registered state and outputs; reset clears everything silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q <= '0;
            lp_cnt_q <= '0;
            level_q  <= 1'b0;
            held_q   <= 1'b0;
            pulse_q  <= '0;
        end else begin
            db_cnt_q <= db_cnt_d;
            lp_cnt_q <= lp_cnt_d;
            level_q  <= level_d;
            held_q   <= held_d;
            pulse_q  <= pulse_d;
        end
    end

    assign level         = level_q;
    assign held          = held_q;
    assign press_pulse   = pulse_q.press;
    assign release_pulse = pulse_q.rel;
    assign long_pulse    = pulse_q.lng;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: 1 cycle = 1 ms, DB_T=4, LONG_T=20,
// REP_T=5. One active-high and one active-low instance share clk/rst.
module tb_input_debounce;

    logic clk;
    logic rst;
    logic i1, i1n;
    logic level, press_pulse, release_pulse, long_pulse, held;
    logic level_n, press_n, release_n, long_n, held_n;

    int checks;
    int errors;
    int press_cnt, rel_cnt, long_cnt;
    int pn_press, pn_rel;

    input_debounce #(
        .F_CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20),
        .IN_ACTIVE_LOW(0), .REPEAT_MS(5)
    ) dut (
        .clk(clk), .rst(rst), .I1(i1),
        .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .held(held)
    );

    input_debounce #(
        .F_CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20),
        .IN_ACTIVE_LOW(1), .REPEAT_MS(5)
    ) dut_n (
        .clk(clk), .rst(rst), .I1(i1n),
        .level(level_n), .press_pulse(press_n), .release_pulse(release_n),
        .long_pulse(long_n), .held(held_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then step 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Event counters and the press/release exclusivity check.
    always @(negedge clk) begin
        if (press_pulse === 1'b1)   press_cnt++;
        if (release_pulse === 1'b1) rel_cnt++;
        if (long_pulse === 1'b1)    long_cnt++;
        if (press_n === 1'b1)       pn_press++;
        if (release_n === 1'b1)     pn_rel++;
        if (!rst) chk("no_both", {31'd0, press_pulse & release_pulse}, 32'd0);
    end

    task automatic clr_cnt();
        press_cnt = 0; rel_cnt = 0; long_cnt = 0;
    endtask

    initial begin
        checks = 0; errors = 0;
        press_cnt = 0; rel_cnt = 0; long_cnt = 0; pn_press = 0; pn_rel = 0;
        rst = 1'b1; i1 = 1'b0; i1n = 1'b1;
        tick(3);
        chk("rst_outs", {27'd0, level, press_pulse, release_pulse, long_pulse, held}, 32'd0);
        chk("rst_outs_n", {27'd0, level_n, press_n, release_n, long_n, held_n}, 32'd0);
        rst = 1'b0;
        tick(3);
        clr_cnt();

        // 1: clean press, 10 cycles
        i1 = 1'b1;
        tick(5);
        chk("c1_lvl_early", {31'd0, level}, 32'd0);
        tick(1);
        chk("c1_lvl_rise", {30'd0, level, press_pulse}, 32'd3);
        tick(1);
        chk("c1_press_1cyc", {31'd0, press_pulse}, 32'd0);
        tick(3);
        i1 = 1'b0;
        tick(5);
        chk("c1_lvl_still", {31'd0, level}, 32'd1);
        tick(1);
        chk("c1_release", {30'd0, level, release_pulse}, 32'd1);
        tick(1);
        chk("c1_rel_1cyc", {31'd0, release_pulse}, 32'd0);
        chk("c1_press_cnt", press_cnt, 32'd1);
        chk("c1_long_cnt", long_cnt, 32'd0);
        tick(3);
        clr_cnt();

        // 2: bounce then steady high
        i1 = 1'b1; tick(1);
        i1 = 1'b0; tick(1);
        i1 = 1'b1; tick(1);
        i1 = 1'b0; tick(1);
        i1 = 1'b1;
        tick(5);
        chk("c2_lvl_early", {31'd0, level}, 32'd0);
        tick(1);
        chk("c2_lvl_rise", {30'd0, level, press_pulse}, 32'd3);
        tick(4);
        chk("c2_press_cnt", press_cnt, 32'd1);
        i1 = 1'b0;
        tick(6);
        chk("c2_release", {30'd0, level, release_pulse}, 32'd1);
        tick(3);
        clr_cnt();

        // 3: long hold, 40 cycles
        i1 = 1'b1;
        tick(6);
        chk("c3_press", {30'd0, level, press_pulse}, 32'd3);
        tick(19);
        chk("c3_pre_long", {30'd0, long_pulse, held}, 32'd0);
        tick(1);
        chk("c3_long", {30'd0, long_pulse, held}, 32'd3);
        tick(1);
        chk("c3_long_1cyc", {30'd0, long_pulse, held}, 32'd1);
        tick(13);
        i1 = 1'b0;
        tick(5);
        chk("c3_held_pre_rel", {29'd0, level, held, release_pulse}, 32'd6);
        tick(1);
        chk("c3_rel_held_clr", {29'd0, level, held, release_pulse}, 32'd1);
        tick(1);
        chk("c3_long_cnt", long_cnt, 32'd1);
`ifdef INPUT_DEBOUNCE_REPEAT_EN
        chk("c3_press_cnt", press_cnt, 32'd4);
`else
        chk("c3_press_cnt", press_cnt, 32'd1);
`endif
        tick(3);
        clr_cnt();

        // 4: reset while held
        i1 = 1'b1;
        tick(26);
        chk("c4_held", {30'd0, level, held}, 32'd3);
        rst = 1'b1;
        tick(1);
        chk("c4_rst_outs", {27'd0, level, press_pulse, release_pulse, long_pulse, held}, 32'd0);
        tick(1);
        chk("c4_rst_outs2", {27'd0, level, press_pulse, release_pulse, long_pulse, held}, 32'd0);
        rst = 1'b0;
        tick(5);
        chk("c4_no_early", {30'd0, level, press_pulse}, 32'd0);
        tick(1);
        chk("c4_repress", {30'd0, level, press_pulse}, 32'd3);
        chk("c4_no_release", rel_cnt, 32'd0);
        i1 = 1'b0;
        tick(6);
        chk("c4_release", {30'd0, level, release_pulse}, 32'd1);
        tick(3);

        // 5: active-low pin, idle activity so far must be none
        chk("c5_idle_n", pn_press + pn_rel, 32'd0);
        i1n = 1'b0;
        tick(5);
        chk("c5_lvl_early", {31'd0, level_n}, 32'd0);
        tick(1);
        chk("c5_lvl_rise", {30'd0, level_n, press_n}, 32'd3);
        tick(1);
        chk("c5_press_1cyc", {31'd0, press_n}, 32'd0);
        tick(3);
        i1n = 1'b1;
        tick(6);
        chk("c5_release", {30'd0, level_n, release_n}, 32'd1);
        tick(2);
        chk("c5_counts", {pn_press[15:0], pn_rel[15:0]}, {16'd1, 16'd1});
        chk("c5_no_long", {31'd0, held_n}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
